dmem_responder: RTL and testbench

Data-side responder for the pipelined RV32 core. It answers the core's data-memory port: byte, halfword and word loads and stores into a word-organised RAM, selected by the core's 3-bit `memop`. It also provides a small memory-mapped machine timer and software-interrupt register that drive the core's `irq_pins`. It sits at the top level between the core's M stage and the interrupt inputs.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_mtimer.sv | 63 ++++++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: memop codes, MMIO offsets,
// decode regions and the byte-lane mask helper.
package dmem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    localparam logic [4:0] MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] MSIP        = 5'h10;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_MMIO
    } region_e;

    // Byte enables for an access; half lanes pick on lane[1] only, so an
    // unaligned half in the permissive build lands on the aligned half.
    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b0000;
        case (op)
            MOP_B, MOP_BU: m = 4'b0001 << lane;
            MOP_H, MOP_HU: m = lane[1] ? 4'b1100 : 4'b0011;
            MOP_W:         m = 4'b1111;
            default:       m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_mtimer.sv
// Machine timer block: prescaler, 64-bit mtime/mtimecmp, msip and the
// registered interrupt pins. Register offsets come from dmem_pkg.
module dmem_mtimer
    import dmem_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        clr_n,
    input  logic        wr_en,
    input  logic [4:0]  wr_off,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_off,
    output logic [31:0] rd_data,
    output logic [1:0]  irq_pins
);

    logic [31:0] presc;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        tick;

    assign tick = (presc == 32'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (!clr_n) begin
            presc    <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            msip     <= 1'b0;
            irq_pins <= 2'b00;
        end else begin
            presc <= tick ? '0 : presc + 32'd1;
            if (tick)
                mtime <= mtime + 64'd1;
            // Compare sees the registers as they stood before this edge, so
            // a mtimecmp/msip write shows on the pins one clock later.
            irq_pins <= {msip, (mtime >= mtimecmp)};
            if (wr_en) begin
                case (wr_off)
                    MTIMECMP_LO: mtimecmp[31:0]  <= wr_data;
                    MTIMECMP_HI: mtimecmp[63:32] <= wr_data;
                    MSIP:        msip            <= wr_data[0];
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            MTIME_LO:    rd_data = mtime[31:0];
            MTIME_HI:    rd_data = mtime[63:32];
            MTIMECMP_LO: rd_data = mtimecmp[31:0];
            MTIMECMP_HI: rd_data = mtimecmp[63:32];
            MSIP:        rd_data = {31'd0, msip};
            default:     rd_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word lanes plus the timer
// MMIO window. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_F000,
    parameter int          TICK_DIV    = 1
) (
    input  logic        clock,
    input  logic        clr_n,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemdatain,
    input  logic        dmemwe,
    input  logic [2:0]  dmemop,
    output logic [31:0] dmemdataout,
    output logic [1:0]  irq_pins
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        fault
`endif
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic [31:0]   mmio_delta;
    logic [31:0]   mmio_rd;
    logic [31:0]   raw;
    logic [31:0]   shifted;
    logic [15:0]   half;
    logic [31:0]   wdata;
    logic [31:0]   ld_val;
    logic [3:0]    mask;
    logic          op_valid;
    logic          misalign;
    logic          access_ok;
    logic          mmio_wr;
    region_e       region;

    assign widx       = dmemaddr[AW+1:2];
    assign mmio_delta = dmemaddr - MMIO_BASE;
    assign mask       = lane_mask(dmemop, dmemaddr[1:0]);
    assign op_valid   = (dmemop == MOP_B) || (dmemop == MOP_H) || (dmemop == MOP_W) ||
                        (dmemop == MOP_BU) || (dmemop == MOP_HU);
    assign misalign   = (((dmemop == MOP_H) || (dmemop == MOP_HU)) && dmemaddr[0]) ||
                        ((dmemop == MOP_W) && (dmemaddr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign access_ok = op_valid && !misalign;

    always_ff @(posedge clock) begin
        if (!clr_n)
            fault <= 1'b0;
        else if (misalign)
            fault <= 1'b1;
    end
`else
    assign access_ok = op_valid;
`endif

    always_comb begin
        region = REGION_NONE;
        if ({1'b0, dmemaddr} < RAM_BYTES)
            region = REGION_RAM;
        else if ((dmemaddr >= MMIO_BASE) && (mmio_delta <= 32'h13))
            region = REGION_MMIO;
    end

    always_comb begin
        wdata = dmemdatain;
        case (dmemop)
            MOP_B, MOP_BU: wdata = {4{dmemdatain[7:0]}};
            MOP_H, MOP_HU: wdata = {2{dmemdatain[15:0]}};
            default:       wdata = dmemdatain;
        endcase
    end

    // RAM is deliberately not reset; a store during reset is still dropped.
    always_ff @(posedge clock) begin
        if (clr_n && dmemwe && access_ok && (region == REGION_RAM)) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i])
                    ram[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign mmio_wr = dmemwe && access_ok && (region == REGION_MMIO) && (dmemop == MOP_W);

    dmem_mtimer #(
        .TICK_DIV (TICK_DIV)
    ) u_mtimer (
        .clock    (clock),
        .clr_n    (clr_n),
        .wr_en    (mmio_wr),
        .wr_off   ({mmio_delta[4:2], 2'b00}),
        .wr_data  (dmemdatain),
        .rd_off   ({mmio_delta[4:2], 2'b00}),
        .rd_data  (mmio_rd),
        .irq_pins (irq_pins)
    );

    always_comb begin
        raw = '0;
        if (region == REGION_RAM)
            raw = ram[widx];
        else if ((region == REGION_MMIO) && (dmemop == MOP_W))
            raw = mmio_rd;
        shifted = raw >> {dmemaddr[1:0], 3'b000};
        half    = dmemaddr[1] ? raw[31:16] : raw[15:0];
        ld_val  = '0;
        if (access_ok) begin
            case (dmemop)
                MOP_B:   ld_val = {{24{shifted[7]}}, shifted[7:0]};
                MOP_BU:  ld_val = {24'd0, shifted[7:0]};
                MOP_H:   ld_val = {{16{half[15]}}, half};
                MOP_HU:  ld_val = {16'd0, half};
                MOP_W:   ld_val = raw;
                default: ld_val = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!clr_n)
            dmemdataout <= '0;
        else
            dmemdataout <= ld_val;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: queue scoreboard of expected load
// data, plus direct checks of irq_pins (and fault when DMEM_MISALIGN_TRAP_EN).
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] MB = 32'hFFFF_F000;

    logic        clock = 1'b0;
    logic        clr_n = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemdatain = '0;
    logic        dmemwe = 1'b0;
    logic [2:0]  dmemop = MOP_W;
    logic [31:0] dmemdataout;
    logic [1:0]  irq_pins;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        fault;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH_WORDS (4096),
        .MMIO_BASE   (MB),
        .TICK_DIV    (1)
    ) dut (
        .clock       (clock),
        .clr_n       (clr_n),
        .dmemaddr    (dmemaddr),
        .dmemdatain  (dmemdatain),
        .dmemwe      (dmemwe),
        .dmemop      (dmemop),
        .dmemdataout (dmemdataout),
        .irq_pins    (irq_pins)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .fault       (fault)
`endif
    );

    // Drive one access, let one edge pass, sample 1 time unit after it.
    task automatic put(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] op);
        dmemwe = we; dmemaddr = a; dmemdatain = d; dmemop = op;
        @(posedge clock); #1;
        dmemwe = 1'b0; dmemaddr = '0; dmemdatain = '0; dmemop = MOP_W;
    endtask

    task automatic apply_reset(input logic we, input logic [31:0] a, input logic [31:0] d);
        clr_n = 1'b0; dmemwe = we; dmemaddr = a; dmemdatain = d; dmemop = MOP_W;
        repeat (3) @(posedge clock);
        #1;
        clr_n = 1'b1; dmemwe = 1'b0; dmemaddr = '0; dmemdatain = '0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; dmemaddr = 32'h10; dmemop = MOP_W;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (dmemdataout !== 32'h0) begin
            errors++; $display("FAIL reset_dataout: got %h want 00000000", dmemdataout);
        end
        checks++;
        if (irq_pins !== 2'b00) begin
            errors++; $display("FAIL reset_irq: got %b want 00", irq_pins);
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL reset_fault: got %b want 0", fault);
        end
`endif
        clr_n = 1'b1;
        // First edge out of reset: mtime still 0, mtimecmp all ones.
        exp_q.push_back(32'h0);
        put(1'b0, MB + 32'h0, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL reset_mtime: got %h want %h", dmemdataout, exp_v);
        end
        exp_q.push_back(32'hFFFF_FFFF);
        put(1'b0, MB + 32'hC, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL reset_mtimecmp: got %h want %h", dmemdataout, exp_v);
        end
    endtask

    task automatic test_word_byte();
        logic [31:0] a [4] = '{32'h10, 32'h10, 32'h13, 32'h12};
        logic [2:0]  o [4] = '{MOP_B, MOP_BU, MOP_B, MOP_H};
        logic [31:0] e [4] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FF80, 32'hFFFF_8000};
        put(1'b1, 32'h10, 32'h8000_00FF, MOP_W);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e[i]);
            put(1'b0, a[i], '0, o[i]);
            exp_v = exp_q.pop_front(); checks++;
            if (dmemdataout !== exp_v) begin
                errors++; $display("FAIL word_byte[%0d]: got %h want %h", i, dmemdataout, exp_v);
            end
        end
    endtask

    task automatic test_halfword();
        logic [31:0] a [4] = '{32'h20, 32'h22, 32'h20, 32'h20};
        logic [2:0]  o [4] = '{MOP_W, MOP_HU, MOP_H, MOP_W};
        logic [31:0] e [4] = '{32'h1234_AAAA, 32'h0000_1234, 32'hFFFF_AAAA, 32'h1234_55AA};
        put(1'b1, 32'h20, 32'hAAAA_AAAA, MOP_W);
        put(1'b1, 32'h22, 32'hFFFF_1234, MOP_H);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) put(1'b1, 32'h21, 32'h0000_0055, MOP_B);
            exp_q.push_back(e[i]);
            put(1'b0, a[i], '0, o[i]);
            exp_v = exp_q.pop_front(); checks++;
            if (dmemdataout !== exp_v) begin
                errors++; $display("FAIL halfword[%0d]: got %h want %h", i, dmemdataout, exp_v);
            end
        end
    endtask

    task automatic test_invalid();
        logic [31:0] a [4] = '{32'h0, 32'h0, 32'h8000_0000, MB + 32'h10};
        logic [2:0]  o [4] = '{MOP_W, 3'b111, MOP_W, MOP_B};
        logic [31:0] e [4] = '{32'h1111_1111, 32'h0, 32'h0, 32'h0};
        put(1'b1, 32'h0, 32'h1111_1111, MOP_W);
        put(1'b1, 32'h0, 32'hDEAD_BEEF, 3'b111);
        put(1'b1, 32'h0, 32'hCAFE_0000, 3'b011);
        put(1'b1, 32'h8000_0000, 32'h5555_5555, MOP_W);
        put(1'b1, MB + 32'h10, 32'h1, MOP_B);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e[i]);
            put(1'b0, a[i], '0, o[i]);
            exp_v = exp_q.pop_front(); checks++;
            if (dmemdataout !== exp_v) begin
                errors++; $display("FAIL invalid[%0d]: got %h want %h", i, dmemdataout, exp_v);
            end
        end
        checks++;
        if (irq_pins[1] !== 1'b0) begin
            errors++; $display("FAIL subword_msip: got %b want 0", irq_pins[1]);
        end
    endtask

    task automatic test_misalign();
        put(1'b1, 32'h40, 32'h1122_3344, MOP_W);
        put(1'b1, 32'h41, 32'hCAFE_BABE, MOP_W);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL misalign_fault_set: got %b want 1", fault);
        end
        exp_q.push_back(32'h1122_3344);
        put(1'b0, 32'h40, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL misalign_suppressed: got %h want %h", dmemdataout, exp_v);
        end
        exp_q.push_back(32'h0);
        put(1'b0, 32'h43, '0, MOP_H);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL misalign_load_zero: got %h want %h", dmemdataout, exp_v);
        end
        repeat (4) put(1'b0, 32'h0, '0, MOP_W);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL misalign_fault_sticky: got %b want 1", fault);
        end
        apply_reset(1'b0, 32'h0, '0);
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL misalign_fault_clear: got %b want 0", fault);
        end
`else
        exp_q.push_back(32'hCAFE_BABE);
        put(1'b0, 32'h40, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL misalign_aligned_store: got %h want %h", dmemdataout, exp_v);
        end
        exp_q.push_back(32'hFFFF_CAFE);
        put(1'b0, 32'h43, '0, MOP_H);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL misalign_aligned_half: got %h want %h", dmemdataout, exp_v);
        end
`endif
    endtask

    task automatic test_boundary();
        put(1'b1, 32'h3FFC, 32'h0BAD_F00D, MOP_W);
        put(1'b1, 32'h4000, 32'h7777_7777, MOP_W);
        exp_q.push_back(32'h0BAD_F00D);
        put(1'b0, 32'h3FFC, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL ram_top: got %h want %h", dmemdataout, exp_v);
        end
        exp_q.push_back(32'h0);
        put(1'b0, 32'h4000, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL ram_past_top: got %h want %h", dmemdataout, exp_v);
        end
        exp_q.push_back(32'h1111_1111);
        put(1'b0, 32'h0, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL ram_no_alias: got %h want %h", dmemdataout, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            v = (32'h0101_0101 * i) ^ 32'hA5A5_0000;
            put(1'b1, 32'h200 + 32'(4 * i), v, MOP_W);
        end
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back((32'h0101_0101 * i) ^ 32'hA5A5_0000);
            put(1'b0, 32'h200 + 32'(4 * i), '0, MOP_W);
            exp_v = exp_q.pop_front(); checks++;
            if (dmemdataout !== exp_v) begin
                errors++; $display("FAIL b2b_load[%0d]: got %h want %h", i, dmemdataout, exp_v);
            end
        end
        // Same-cycle store and load of one word sees the old contents.
        exp_q.push_back(32'hA5A5_0000);
        put(1'b1, 32'h200, 32'hFFFF_0000, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL no_forward: got %h want %h", dmemdataout, exp_v);
        end
        exp_q.push_back(32'hFFFF_0000);
        put(1'b0, 32'h200, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL store_then_load: got %h want %h", dmemdataout, exp_v);
        end
    endtask

    task automatic test_timer();
        apply_reset(1'b0, 32'h0, '0);
        put(1'b1, MB + 32'h8, 32'd5, MOP_W);   // edge 1
        put(1'b1, MB + 32'hC, 32'd0, MOP_W);   // edge 2
        for (int k = 3; k <= 12; k++) begin
            exp_q.push_back(32'(k - 1));
            put(1'b0, MB + 32'h0, '0, MOP_W);
            exp_v = exp_q.pop_front(); checks++;
            if (dmemdataout !== exp_v) begin
                errors++; $display("FAIL mtime_edge%0d: got %h want %h", k, dmemdataout, exp_v);
            end
            checks++;
            if (irq_pins[0] !== (k >= 6)) begin
                errors++; $display("FAIL mtip_edge%0d: got %b want %b", k, irq_pins[0], (k >= 6));
            end
        end
        put(1'b1, MB + 32'hC, 32'hFFFF_FFFF, MOP_W);
        checks++;
        if (irq_pins[0] !== 1'b1) begin
            errors++; $display("FAIL mtip_hold: got %b want 1", irq_pins[0]);
        end
        exp_q.push_back(32'd5);
        put(1'b0, MB + 32'h8, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL mtimecmp_lo_rd: got %h want %h", dmemdataout, exp_v);
        end
        checks++;
        if (irq_pins[0] !== 1'b0) begin
            errors++; $display("FAIL mtip_clear: got %b want 0", irq_pins[0]);
        end
    endtask

    task automatic test_msip();
        put(1'b1, MB + 32'h10, 32'h1, MOP_W);
        checks++;
        if (irq_pins[1] !== 1'b0) begin
            errors++; $display("FAIL msip_lag: got %b want 0", irq_pins[1]);
        end
        exp_q.push_back(32'h1);
        put(1'b0, MB + 32'h10, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL msip_rd1: got %h want %h", dmemdataout, exp_v);
        end
        checks++;
        if (irq_pins[1] !== 1'b1) begin
            errors++; $display("FAIL msip_set: got %b want 1", irq_pins[1]);
        end
        put(1'b1, MB + 32'h10, 32'hFFFF_FFFE, MOP_W);
        exp_q.push_back(32'h0);
        put(1'b0, MB + 32'h10, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL msip_rd0: got %h want %h", dmemdataout, exp_v);
        end
        checks++;
        if (irq_pins[1] !== 1'b0) begin
            errors++; $display("FAIL msip_clear: got %b want 0", irq_pins[1]);
        end
    endtask

    task automatic test_reset_drop();
        put(1'b1, 32'h50, 32'h600D_600D, MOP_W);
        apply_reset(1'b1, 32'h50, 32'h0BAD_0BAD);
        exp_q.push_back(32'h600D_600D);
        put(1'b0, 32'h50, '0, MOP_W);
        exp_v = exp_q.pop_front(); checks++;
        if (dmemdataout !== exp_v) begin
            errors++; $display("FAIL reset_store_drop: got %h want %h", dmemdataout, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_halfword();
        test_invalid();
        test_misalign();
        test_boundary();
        test_back_to_back();
        test_timer();
        test_msip();
        test_reset_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
